// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC register with branch/jump redirect, freeze-held branch and flush control
// A branch seen during a freeze is parked in HOLD and applied on the first unstalled cycle.
module pc_redirect_unit #(
  parameter int unsigned                PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]        RESET_PC  = '0,
  parameter int unsigned                CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_addr,
  input  logic                 jump_valid,
  input  logic [PC_WIDTH-1:0]  jump_addr,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  next_pc,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 flush_ex_mem,
  output logic                 redirect_pending,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   held_q, held_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  branch_apply;
  logic                  flush_all;
  logic                  flush_jump;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      held_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    held_d       = held_q;
    branch_apply = 1'b0;
    flush_all    = 1'b0;
    flush_jump   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken && !stall) begin
          pc_d         = branch_addr;
          branch_apply = 1'b1;
          flush_all    = 1'b1;
        end else if (branch_taken) begin
          held_d  = branch_addr;
          state_d = HOLD;
        end else if (jump_valid && !stall) begin
          pc_d       = jump_addr;
          flush_jump = 1'b1;
        end else if (!stall) begin
          pc_d = pc_q + 1'b1;
        end
      end
      HOLD: begin
        // New branch/jump inputs are ignored here: the older held target wins.
        if (!stall) begin
          pc_d         = held_q;
          branch_apply = 1'b1;
          flush_all    = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (branch_apply && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign pc               = pc_q;
  assign next_pc          = pc_q + 1'b1;
  assign flush_if_id      = !rst && (flush_all || flush_jump);
  assign flush_id_ex      = !rst && flush_all;
  assign flush_ex_mem     = !rst && flush_all;
  assign redirect_pending = (state_q == HOLD);
  assign redirect_count   = cnt_q;

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Fetch-side consumer of the MEM-stage branch resolution result (branch_taken / branch_addr from bru) and of ID-stage jump resolution.
- Owns the program counter register and selects the next fetch address.
- Generates the pipeline-register flush controls for IF/ID, ID/EX and EX/MEM.
- Holds a branch redirect that arrives during a pipeline freeze and applies it when the freeze releases.

Parameters:
PC_WIDTH, 32, width of pc / addresses (matches `PC_WIDTH); word-addressed
RESET_PC, 0, pc value loaded on reset
CNT_WIDTH, 16, width of redirect_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  global pipeline freeze (hazard / memory wait)
branch_taken  input  1  single-cycle pulse from bru, MEM stage
branch_addr  input  PC_WIDTH  branch target, valid with branch_taken
jump_valid  input  1  unconditional jump resolved in ID
jump_addr  input  PC_WIDTH  jump target, valid with jump_valid
pc  output  PC_WIDTH  current fetch address to instruction memory (registered)
next_pc  output  PC_WIDTH  pc + 1, forwarded into IF/ID (combinational from pc)
flush_if_id  output  1  clear IF/ID at next edge
flush_id_ex  output  1  clear ID/EX at next edge
flush_ex_mem  output  1  clear EX/MEM at next edge
redirect_pending  output  1  a held branch redirect is waiting (state HOLD)
redirect_count  output  CNT_WIDTH  saturating count of applied branch redirects

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset (edge with rst=1):
  - pc=RESET_PC, next_pc=RESET_PC+1, state=RUN.
  - redirect_pending=0, held address=0, redirect_count=0.
  - All flush outputs are 0 while rst=1, whatever the other inputs.
  - A reset during HOLD discards the held redirect.
- Arithmetic: next_pc = pc+1 modulo 2^PC_WIDTH. All-ones wraps to 0 with no flag.
- States: RUN, HOLD.
- RUN, evaluated each cycle, highest priority first:
  1. branch_taken=1 and stall=0: pc<=branch_addr. flush_if_id=flush_id_ex=flush_ex_mem=1 this cycle (combinational). Count increments. Any simultaneous jump_valid is discarded.
  2. branch_taken=1 and stall=1: latch branch_addr. State goes to HOLD and redirect_pending=1 from the next cycle. pc holds, no flush this cycle.
  3. jump_valid=1 and stall=0: pc<=jump_addr. flush_if_id=1 only.
  4. stall=1: pc holds. jump_valid is ignored, because frozen ID re-presents it.
  5. Otherwise: pc<=pc+1.
- HOLD:
  - While stall=1: pc holds, no flushes.
  - Further branch_taken or jump_valid inputs are ignored. The held (older) target wins and is not overwritten.
  - First cycle with stall=0: pc<=held address, all three flushes=1 for that cycle, count increments, state returns to RUN. redirect_pending drops to 0 on the following cycle.
  - branch_taken or jump_valid on that release cycle is ignored.
- Latency:
  - Redirect in RUN takes effect at the next edge (1 cycle).
  - Held redirect takes effect at the edge ending the first unstalled cycle.
- Flush outputs:
  - Combinational from state and inputs.
  - Asserted only on the cycle the redirect is applied, never while stall=1.
- redirect_count:
  - Counts branch redirects only, not jumps.
  - Saturates at all-ones and stays there.

Test Plan:
- Reset then run: rst=1 for 2 cycles, then 4 free cycles -> pc 0,0,1,2,3,4; next_pc=pc+1; all flushes 0; redirect_count=0.
- Branch in RUN: at pc=5, pulse branch_taken with branch_addr=0x40 -> that cycle all 3 flushes=1; next cycle pc=0x40 with flushes 0; redirect_count=1.
- Branch during stall: stall=1 for 3 cycles, branch_taken pulse (addr 0x80) in the first of them -> redirect_pending=1 from the 2nd stalled cycle, pc frozen. On first stall=0 cycle all flushes=1; next cycle pc=0x80, pending=0, count=1. A jump_valid (0x99) during HOLD must have no effect.
- Branch vs jump collision: branch_taken (0x10) and jump_valid (0x20) in the same unstalled cycle -> pc=0x10, all three flushes; jump discarded. A lone jump to 0x20 later -> only flush_if_id=1, count unchanged.
- Wrap and saturation: force pc to 0xFFFFFFFF via branch -> next cycle pc=0. Apply 65536 branches -> redirect_count reads 0xFFFF.
- Reset mid-HOLD: enter HOLD (addr 0x80), assert rst for 1 cycle -> pc=RESET_PC, pending=0, count=0. After stall=0, pc increments from 0 and is never 0x80.
